// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//
// Target end of the CPU data-memory request/response interface. It accepts
// one load or store at a time, waits LATENCY clock edges (the accept edge
// counts as the first), commits the access to a word-organised storage array
// and then presents a response. The response is held until the initiator
// takes it.
//
// Ports
//   i_clk            system clock, rising edge
//   i_reset          asynchronous, active-high reset
//   i_req_valid      initiator presents a request
//   o_req_ready      responder can accept a request this cycle
//   i_req_we         1 = store, 0 = load
//   i_req_addr       byte address
//   i_req_size       00 byte, 01 half, 10 word, 11 reserved
//   i_req_unsigned   load zero-extends when 1, sign-extends when 0
//   i_req_wdata      store data, right-aligned
//   o_resp_valid     response available
//   i_resp_ready     initiator accepts the response
//   o_resp_rdata     extended load result; 0 for stores and faulted accesses
//   o_resp_err       access faulted; nothing was written
// ----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH) * 33'd4;
    localparam bit          LAT_ONE   = (LATENCY == 1);
    localparam logic [3:0]  CNT_INIT  = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_wdata;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    logic [31:0] r_mem [DEPTH];

    logic        w_accept;
    logic        w_sel_in;
    logic        w_we;
    logic [31:0] w_addr;
    logic [1:0]  w_size;
    logic        w_unsigned;
    logic [31:0] w_wdata;
    logic        w_commit;
    logic        w_err;
    logic [AW-1:0] w_idx;
    logic [3:0]  w_be;
    logic [31:0] w_wlanes;
    logic [31:0] w_word;
    logic [31:0] w_shifted;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_rdata;

    assign o_req_ready  = (r_state == S_IDLE) && !i_reset;
    assign w_accept     = i_req_valid && o_req_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;

    // With LATENCY==1 the commit happens on the accept edge itself, so the
    // access must be taken straight from the request inputs; in every other
    // case it comes from the captured copy.
    assign w_sel_in   = (r_state == S_IDLE);
    assign w_we       = w_sel_in ? i_req_we       : r_we;
    assign w_addr     = w_sel_in ? i_req_addr     : r_addr;
    assign w_size     = w_sel_in ? i_req_size     : r_size;
    assign w_unsigned = w_sel_in ? i_req_unsigned : r_unsigned;
    assign w_wdata    = w_sel_in ? i_req_wdata    : r_wdata;

    assign w_commit = (LAT_ONE && (r_state == S_IDLE) && w_accept) ||
                      ((r_state == S_WAIT) && (r_cnt == 4'd0));

    assign w_idx = w_addr[AW+1:2];

    // Faults: misaligned half/word, reserved size, or beyond the array. No
    // wrap-around is applied, so large addresses always fault.
    always_comb begin
        w_err = 1'b0;
        case (w_size)
            2'b01:   w_err = w_addr[0];
            2'b10:   w_err = (w_addr[1:0] != 2'b00);
            2'b11:   w_err = 1'b1;
            default: w_err = 1'b0;
        endcase
        if ({1'b0, w_addr} >= MEM_BYTES) begin
            w_err = 1'b1;
        end
    end

    // Store lane selection: the right-aligned data is replicated across the
    // word so that the byte enables alone pick the destination lanes.
    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = w_wdata;
        case (w_size)
            2'b00: begin
                w_be     = 4'b0001 << w_addr[1:0];
                w_wlanes = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be     = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{w_wdata[15:0]}};
            end
            2'b10: begin
                w_be     = 4'b1111;
                w_wlanes = w_wdata;
            end
            default: begin
                w_be     = 4'b0000;
                w_wlanes = w_wdata;
            end
        endcase
    end

    // Load extraction and extension; stores and faults return zero.
    always_comb begin
        w_word    = r_mem[w_idx];
        w_shifted = w_word >> {w_addr[1:0], 3'b000};
        w_half    = w_addr[1] ? w_word[31:16] : w_word[15:0];
        w_load    = 32'd0;
        case (w_size)
            2'b00:   w_load = {{24{!w_unsigned && w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load = {{16{!w_unsigned && w_half[15]}}, w_half};
            2'b10:   w_load = w_word;
            default: w_load = 32'd0;
        endcase
        w_rdata = (w_err || w_we) ? 32'd0 : w_load;
    end

    // Storage array; deliberately not reset. A commit can only occur after an
    // accept, and accepts are blocked while reset is high, so an in-flight
    // store that is reset before its commit edge never reaches the array.
    always_ff @(posedge i_clk) begin
        if (w_commit && w_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
                end
            end
        end
    end

    // Transaction sequencer: IDLE -> (WAIT) -> RESP -> IDLE. The response
    // fields are captured on the commit edge and held until the handshake.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_addr       <= 32'd0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_wdata      <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we       <= i_req_we;
                        r_addr     <= i_req_addr;
                        r_size     <= i_req_size;
                        r_unsigned <= i_req_unsigned;
                        r_wdata    <= i_req_wdata;
                        if (LAT_ONE) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= w_rdata;
                            r_resp_err   <= w_err;
                        end else begin
                            r_cnt   <= CNT_INIT;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_rdata;
                        r_resp_err   <= w_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (i_resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Drives three responders built with LATENCY = 1, 2 and 4 from the same
// request stream. A byte-level memory model per instance predicts every
// response from the access rules (alignment, range, lanes, extension); the
// response latency of each instance is measured in clock edges counting the
// accept edge as the first.
// ----------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int DEPTH     = 1024;
    localparam int MEM_BYTES = DEPTH * 4;
    localparam int NDUT      = 3;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic [2:0]  req_ready;
    logic [2:0]  resp_valid;
    logic [2:0]  resp_err;
    logic [31:0] resp_rdata [NDUT];

    logic [7:0]  mdl   [NDUT][MEM_BYTES];
    bit          known [NDUT][MEM_BYTES];

    logic [31:0] lastRd  [NDUT];
    logic        lastErr [NDUT];

    int vectors;
    int miscompares;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut_l1 (
        .i_clk(clk), .i_reset(reset),
        .i_req_valid(req_valid), .o_req_ready(req_ready[0]),
        .i_req_we(req_we), .i_req_addr(req_addr), .i_req_size(req_size),
        .i_req_unsigned(req_unsigned), .i_req_wdata(req_wdata),
        .o_resp_valid(resp_valid[0]), .i_resp_ready(resp_ready),
        .o_resp_rdata(resp_rdata[0]), .o_resp_err(resp_err[0])
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut_l2 (
        .i_clk(clk), .i_reset(reset),
        .i_req_valid(req_valid), .o_req_ready(req_ready[1]),
        .i_req_we(req_we), .i_req_addr(req_addr), .i_req_size(req_size),
        .i_req_unsigned(req_unsigned), .i_req_wdata(req_wdata),
        .o_resp_valid(resp_valid[1]), .i_resp_ready(resp_ready),
        .o_resp_rdata(resp_rdata[1]), .o_resp_err(resp_err[1])
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(4)) u_dut_l4 (
        .i_clk(clk), .i_reset(reset),
        .i_req_valid(req_valid), .o_req_ready(req_ready[2]),
        .i_req_we(req_we), .i_req_addr(req_addr), .i_req_size(req_size),
        .i_req_unsigned(req_unsigned), .i_req_wdata(req_wdata),
        .o_resp_valid(resp_valid[2]), .i_resp_ready(resp_ready),
        .o_resp_rdata(resp_rdata[2]), .o_resp_err(resp_err[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int latOf(input int d);
        return (d == 0) ? 1 : (d == 1) ? 2 : 4;
    endfunction

    // Reference access: little-endian byte memory, natural alignment rule,
    // no address wrap. Returns the expected error, read data, and whether
    // every byte read has a defined value.
    function automatic void refAccess(input int d, input bit we,
                                      input logic [31:0] addr, input logic [1:0] size,
                                      input bit uns, input logic [31:0] wdata,
                                      output bit err, output logic [31:0] rd,
                                      output bit kn);
        int nb;
        int base;
        logic [31:0] v;
        nb  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        err = (size == 2'b11) || (addr >= 32'(MEM_BYTES)) || ((addr % 32'(nb)) != 32'd0);
        rd  = 32'd0;
        kn  = 1'b1;
        if (err) return;
        base = int'(addr);
        if (we) begin
            for (int i = 0; i < nb; i++) begin
                mdl[d][base + i]   = wdata[8*i +: 8];
                known[d][base + i] = 1'b1;
            end
        end else begin
            v = 32'd0;
            for (int i = 0; i < nb; i++) begin
                if (!known[d][base + i]) kn = 1'b0;
                v[8*i +: 8] = mdl[d][base + i];
            end
            if (!uns && nb < 4 && v[8*nb - 1]) begin
                for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
            end
            rd = v;
        end
    endfunction

    task automatic scrambleReq();
        req_we       = 1'($urandom);
        req_addr     = $urandom;
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_wdata    = $urandom;
    endtask

    // One transaction through all three instances with resp_ready held high.
    task automatic doTxn(input bit we, input logic [31:0] addr, input logic [1:0] size,
                         input bit uns, input logic [31:0] wdata);
        bit          eErr [NDUT];
        logic [31:0] eRd  [NDUT];
        bit          eKn  [NDUT];
        int          seen [NDUT];
        for (int d = 0; d < NDUT; d++) begin
            refAccess(d, we, addr, size, uns, wdata, eErr[d], eRd[d], eKn[d]);
            seen[d] = 0;
        end
        @(negedge clk);
        resp_ready   = 1'b1;
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        vectors++;
        if (req_ready !== 3'b111) begin
            miscompares++;
            $display("[TB] FAIL req_ready_idle: got %b want 111", req_ready);
        end
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            req_valid = 1'b0;
            scrambleReq();
            for (int d = 0; d < NDUT; d++) begin
                if (seen[d] == 0 && resp_valid[d] === 1'b1) begin
                    seen[d]    = n;
                    lastRd[d]  = resp_rdata[d];
                    lastErr[d] = resp_err[d];
                    vectors++;
                    if (n != latOf(d)) begin
                        miscompares++;
                        $display("[TB] FAIL latency dut%0d addr %h: got %0d edges want %0d",
                                 d, addr, n, latOf(d));
                    end
                    vectors++;
                    if (resp_err[d] !== eErr[d]) begin
                        miscompares++;
                        $display("[TB] FAIL resp_err dut%0d addr %h size %0d we %0d: got %b want %b",
                                 d, addr, size, we, resp_err[d], eErr[d]);
                    end
                    if (eKn[d]) begin
                        vectors++;
                        if (resp_rdata[d] !== eRd[d]) begin
                            miscompares++;
                            $display("[TB] FAIL resp_rdata dut%0d addr %h size %0d we %0d uns %0d: got %h want %h",
                                     d, addr, size, we, uns, resp_rdata[d], eRd[d]);
                        end
                    end
                end
            end
            if (seen[0] != 0 && seen[1] != 0 && seen[2] != 0 && n >= 6) break;
        end
        for (int d = 0; d < NDUT; d++) begin
            if (seen[d] == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL timeout dut%0d addr %h: resp_valid never seen, want it after %0d edges",
                         d, addr, latOf(d));
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            vectors++;
            if (req_ready[d] !== 1'b0 || resp_valid[d] !== 1'b0 ||
                resp_err[d] !== 1'b0 || resp_rdata[d] !== 32'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_state dut%0d: ready %b valid %b err %b rdata %h want 0 0 0 0",
                         d, req_ready[d], resp_valid[d], resp_err[d], resp_rdata[d]);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 3'b111) begin
            miscompares++;
            $display("[TB] FAIL reset_release_ready: got %b want 111", req_ready);
        end
    endtask

    task automatic test_init();
        for (int w = 0; w < 32; w++) doTxn(1'b1, 32'(w * 4), 2'b10, 1'b0, $urandom);
        doTxn(1'b1, 32'(MEM_BYTES - 4), 2'b10, 1'b0, 32'hCAFEF00D);
    endtask

    task automatic test_word();
        doTxn(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
        vectors++;
        if (lastRd[1] !== 32'd0 || lastErr[1] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL word_store_resp: rdata %h err %b want 00000000 0", lastRd[1], lastErr[1]);
        end
        doTxn(1'b0, 32'h10, 2'b10, 1'b0, 32'd0);
        vectors++;
        if (lastRd[1] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("[TB] FAIL word_load: got %h want DEADBEEF", lastRd[1]);
        end
    endtask

    task automatic test_lanes();
        doTxn(1'b1, 32'h13, 2'b00, 1'b0, 32'h00000080);
        doTxn(1'b0, 32'h13, 2'b00, 1'b0, 32'd0);
        vectors++;
        if (lastRd[1] !== 32'hFFFFFF80) begin
            miscompares++;
            $display("[TB] FAIL byte_signed: got %h want FFFFFF80", lastRd[1]);
        end
        doTxn(1'b0, 32'h13, 2'b00, 1'b1, 32'd0);
        vectors++;
        if (lastRd[1] !== 32'h00000080) begin
            miscompares++;
            $display("[TB] FAIL byte_unsigned: got %h want 00000080", lastRd[1]);
        end
        doTxn(1'b0, 32'h10, 2'b10, 1'b0, 32'd0);
        vectors++;
        if (lastRd[1] !== 32'h80ADBEEF) begin
            miscompares++;
            $display("[TB] FAIL byte_merge_word: got %h want 80ADBEEF", lastRd[1]);
        end
    endtask

    task automatic test_half();
        doTxn(1'b1, 32'h20, 2'b10, 1'b0, 32'hAAAAAAAA);
        doTxn(1'b1, 32'h22, 2'b01, 1'b0, 32'h00001234);
        doTxn(1'b0, 32'h20, 2'b10, 1'b0, 32'd0);
        vectors++;
        if (lastRd[1] !== 32'h1234AAAA) begin
            miscompares++;
            $display("[TB] FAIL half_merge_word: got %h want 1234AAAA", lastRd[1]);
        end
        doTxn(1'b0, 32'h22, 2'b01, 1'b0, 32'd0);
        vectors++;
        if (lastRd[1] !== 32'h00001234) begin
            miscompares++;
            $display("[TB] FAIL half_signed: got %h want 00001234", lastRd[1]);
        end
    endtask

    task automatic test_errors();
        doTxn(1'b0, 32'h11, 2'b10, 1'b0, 32'd0);
        vectors++;
        if (lastErr[1] !== 1'b1 || lastRd[1] !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL err_misaligned_word: err %b rdata %h want 1 00000000", lastErr[1], lastRd[1]);
        end
        doTxn(1'b1, 32'(MEM_BYTES), 2'b10, 1'b0, 32'h12345678);
        vectors++;
        if (lastErr[2] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL err_out_of_range: err %b want 1", lastErr[2]);
        end
        doTxn(1'b0, 32'(MEM_BYTES - 4), 2'b10, 1'b0, 32'd0);
        vectors++;
        if (lastRd[2] !== 32'hCAFEF00D) begin
            miscompares++;
            $display("[TB] FAIL last_word_intact: got %h want CAFEF00D", lastRd[2]);
        end
        doTxn(1'b0, 32'h20, 2'b11, 1'b0, 32'd0);
        vectors++;
        if (lastErr[0] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL err_reserved_size: err %b want 1", lastErr[0]);
        end
        doTxn(1'b1, 32'h21, 2'b01, 1'b0, 32'h0000FFFF);
        doTxn(1'b1, 32'hFFFFFFFC, 2'b10, 1'b0, 32'h0BADF00D);
        doTxn(1'b0, 32'hFFFFFFFC, 2'b10, 1'b0, 32'd0);
        vectors++;
        if (lastErr[1] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL err_no_wrap: err %b want 1", lastErr[1]);
        end
    endtask

    task automatic test_backpressure();
        bit          eErr;
        bit          eKn;
        logic [31:0] eRd [NDUT];
        for (int d = 0; d < NDUT; d++) refAccess(d, 1'b0, 32'h20, 2'b10, 1'b0, 32'd0, eErr, eRd[d], eKn);
        @(negedge clk);
        resp_ready   = 1'b0;
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_addr     = 32'h20;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_wdata    = 32'd0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            req_valid = 1'b0;
            scrambleReq();
            vectors++;
            if (req_ready !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL stall_req_ready cycle %0d: got %b want 000", n, req_ready);
            end
            for (int d = 0; d < NDUT; d++) begin
                vectors++;
                if (n >= latOf(d)) begin
                    if (resp_valid[d] !== 1'b1 || resp_err[d] !== 1'b0 || resp_rdata[d] !== eRd[d]) begin
                        miscompares++;
                        $display("[TB] FAIL stall_hold dut%0d cycle %0d: valid %b err %b rdata %h want 1 0 %h",
                                 d, n, resp_valid[d], resp_err[d], resp_rdata[d], eRd[d]);
                    end
                end else if (resp_valid[d] !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL stall_early dut%0d cycle %0d: valid %b want 0", d, n, resp_valid[d]);
                end
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (resp_valid !== 3'b000 || req_ready !== 3'b111) begin
            miscompares++;
            $display("[TB] FAIL after_handshake: valid %b ready %b want 000 111", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid_wait();
        doTxn(1'b1, 32'h40, 2'b10, 1'b0, 32'h11223344);
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_addr     = 32'h40;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_wdata    = 32'h00000055;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            vectors++;
            if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b0 ||
                resp_err[d] !== 1'b0 || resp_rdata[d] !== 32'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_mid dut%0d: valid %b ready %b err %b rdata %h want 0 0 0 0",
                         d, resp_valid[d], req_ready[d], resp_err[d], resp_rdata[d]);
            end
            // Two edges elapsed since the accept: only latencies up to 2 committed.
            if (latOf(d) <= 2) begin
                mdl[d][32'h40]   = 8'h55;
                known[d][32'h40] = 1'b1;
            end
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        doTxn(1'b0, 32'h40, 2'b00, 1'b1, 32'd0);
        vectors++;
        if (lastRd[2] !== 32'h00000044) begin
            miscompares++;
            $display("[TB] FAIL dropped_store: got %h want 00000044", lastRd[2]);
        end
        vectors++;
        if (lastRd[0] !== 32'h00000055) begin
            miscompares++;
            $display("[TB] FAIL committed_store: got %h want 00000055", lastRd[0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          r;
        for (int k = 0; k < 150; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 8)       a = 32'($urandom_range(0, 127));
            else if (r == 8) a = 32'(MEM_BYTES - 8) + 32'($urandom_range(0, 7));
            else             a = $urandom | 32'(MEM_BYTES);
            doTxn(1'($urandom), a, 2'($urandom), 1'($urandom), $urandom);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 32'd0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_wdata    = 32'd0;
        resp_ready   = 1'b1;
        test_reset();
        test_init();
        test_word();
        test_lanes();
        test_half();
        test_errors();
        test_backpressure();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder (target) end of the CPU data-memory request/response interface: accepts one load or store at a time from the core's load/store path, waits a programmable latency, then returns a response.
- Owns a word-organised storage array with byte and halfword lane handling, load sign/zero extension, and error signalling for misaligned, reserved-size or out-of-range accesses.
- Replaces the zero-latency data memory wherever the core must tolerate wait states.

Parameters:
DEPTH, 1024, number of 32-bit words in the array; valid byte addresses are 0 .. DEPTH*4-1
LATENCY, 2, cycles from request accept to resp_valid assertion; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  initiator presents a request
req_ready  output  1  responder can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  output  1  response available
resp_ready  input  1  initiator accepts the response
resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors
resp_err  output  1  access faulted; no state change occurred

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0. req_ready=0 while reset is high. Array contents are not cleared.
- States: IDLE, WAIT, RESP. req_ready = (state==IDLE) and not reset.
- IDLE: on req_valid & req_ready, register we/addr/size/unsigned/wdata.
  - If LATENCY==1, go to RESP.
  - Otherwise load counter with LATENCY-2 and go to WAIT.
- WAIT: counter decrements each cycle. When counter==0, go to RESP on that edge.
- resp_valid rises exactly LATENCY clock edges after the accept edge.
- Commit on the edge that enters RESP:
  - Stores: write only the addressed lanes. Byte lane = addr[1:0]; half lanes = addr[1]*2 and addr[1]*2+1; word writes all lanes.
  - Loads: sample the word and extract the byte at addr[1:0] or the half at addr[1]. Extend per req_unsigned; word loads are not extended.
- Errors: any of these sets resp_err=1 and resp_rdata=0 and suppresses the write.
  - half access with addr[0]=1
  - word access with addr[1:0]!=0
  - size==11
  - addr >= DEPTH*4
  - Error responses use the same latency as normal responses.
- RESP: resp_valid=1. resp_rdata and resp_err are held stable until resp_valid & resp_ready. On that edge go to IDLE and clear resp_valid.
- Stall and overlap: resp_ready low holds RESP indefinitely. A new request cannot be accepted until the cycle after the response handshake, so at most one transaction is outstanding.
- req_* inputs are ignored outside the accept cycle. Changes to them during WAIT or RESP have no effect.
- Reset mid-transaction: a store reset before its commit edge is dropped. A store already committed persists. Any pending response is discarded.
- Address wrap: addresses are not wrapped. Anything >= DEPTH*4 is an error, including 0xFFFFFFFC.

Test Plan:
- Word store/load, LATENCY=2: store addr 0x10, data 0xDEADBEEF, size 10 -> resp_valid 2 edges after accept with err=0, rdata=0. Then load word 0x10 -> rdata 0xDEADBEEF.
- Sub-word lanes and extension: store byte 0x80 to 0x13, then load byte 0x13 signed -> 0xFFFFFF80; unsigned -> 0x00000080. Load word 0x10 -> 0x80ADBEEF.
- Half lanes: store half 0x1234 to 0x22 over an existing word 0xAAAAAAAA at 0x20 -> load word 0x20 returns 0x1234AAAA. Load half 0x22 signed -> 0x00001234.
- Errors: load word 0x11 -> err=1, rdata=0. Store word to DEPTH*4 -> err=1 and a later readback of the last valid word is unchanged. size 11 -> err=1.
- Backpressure and latency: LATENCY=1 with resp_ready low for 5 cycles -> resp_valid held and rdata stable, req_ready=0 throughout. req_ready returns the cycle after the handshake.
- Reset mid-WAIT (LATENCY=4): assert reset 2 cycles after accepting store 0x55 to byte 0x40 -> resp_valid=0 immediately. After release, load byte 0x40 returns its prior value.
